// File: rtl/imem_arbiter_if.sv
// IFU/LSU request-response channels plus the shared memory port seen by imem_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface imem_arbiter_if #(
  parameter int unsigned AW = 11
);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [31:0]   ifu_req_addr;
  logic          ifu_resp_valid;
  logic          ifu_resp_ready;
  logic [31:0]   ifu_resp_data;
  logic          ifu_resp_err;
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [31:0]   lsu_req_addr;
  logic          lsu_req_wen;
  logic [31:0]   lsu_req_wdata;
  logic [3:0]    lsu_req_wmask;
  logic          lsu_resp_valid;
  logic          lsu_resp_ready;
  logic [31:0]   lsu_resp_rdata;
  logic          lsu_resp_err;
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
           lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
           lsu_resp_ready, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
           lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
           lsu_resp_ready, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one single-port fixed-latency memory between IFU and LSU, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed LSU priority.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned AW          = 11,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          grant_lsu, grant_ifu, req_hs, resp_hs, req_ok, lsu_first;
  logic [31:0]   req_addr, req_off;
  logic          own_lsu, t_wen, t_err;
  logic [AW-1:0] t_widx;
  logic [31:0]   t_wdata, resp_data;
  logic [3:0]    t_wmask, cnt;

`ifdef ARB_ROUND_ROBIN_EN
  // last_lsu: 0 = IFU was granted last, 1 = LSU; a tie goes to the other side
  logic last_lsu;
  always_ff @(posedge clk) begin
    if (!rst_n)      last_lsu <= 1'b0;
    else if (req_hs) last_lsu <= grant_lsu;
  end
  assign lsu_first = !last_lsu;
`else
  assign lsu_first = 1'b1;
`endif

  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (rst_n && state == IDLE) begin
      grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || lsu_first);
      grant_ifu = bus.ifu_req_valid && !grant_lsu;
    end
    req_hs   = grant_lsu || grant_ifu;
    req_addr = grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
    req_off  = req_addr - BASE_ADDR;
    req_ok   = (req_addr >= BASE_ADDR) && ((req_off >> 2) < DEPTH_WORDS)
               && (req_addr[1:0] == 2'b00);
    resp_hs  = own_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs) state_nxt = req_ok ? ACCESS : RESP;
      ACCESS:  state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_lsu   <= 1'b0;
      t_wen     <= 1'b0;
      t_err     <= 1'b0;
      t_widx    <= '0;
      t_wdata   <= '0;
      t_wmask   <= '0;
      cnt       <= '0;
      resp_data <= '0;
    end else begin
      if (req_hs) begin
        own_lsu   <= grant_lsu;
        t_wen     <= grant_lsu && bus.lsu_req_wen;
        t_err     <= !req_ok;
        t_widx    <= req_off[AW+1:2];
        t_wdata   <= grant_lsu ? bus.lsu_req_wdata : '0;
        t_wmask   <= grant_lsu ? bus.lsu_req_wmask : '0;
        // error payload; replaced by memory data when an access follows
        resp_data <= grant_lsu ? '0 : NOP_INSN;
      end
      if (state == ACCESS)    cnt <= 4'(MEM_LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state_nxt == RESP && (state == ACCESS || state == WAIT))
        resp_data <= (own_lsu && t_wen) ? '0 : bus.mem_rdata;
    end
  end

  always_comb begin
    bus.ifu_req_ready  = grant_ifu;
    bus.lsu_req_ready  = grant_lsu;
    bus.mem_en         = (state == ACCESS);
    bus.mem_wen        = (state == ACCESS) && t_wen;
    bus.mem_addr       = t_widx;
    bus.mem_wdata      = t_wdata;
    bus.mem_wmask      = t_wmask;
    bus.ifu_resp_valid = (state == RESP) && !own_lsu;
    bus.lsu_resp_valid = (state == RESP) && own_lsu;
    bus.ifu_resp_data  = resp_data;
    bus.lsu_resp_rdata = resp_data;
    bus.ifu_resp_err   = t_err && !own_lsu;
    bus.lsu_resp_err   = t_err && own_lsu;
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: transaction-level reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_imem_arbiter;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) bus ();
  imem_arbiter #(.MEM_LATENCY(LAT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkb(string name, logic act, logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endfunction

  function automatic logic [31:0] init_word(int unsigned i);
    return (i == 0) ? 32'h0050_0093 : 32'h1111_1111 * i;
  endfunction

  // environment memory: read data appears LAT-1 cycles after the mem_en cycle
  logic [31:0] mem_arr [DEPTH];
  logic [31:0] rd_q [LAT+1];
  logic [31:0] rd_comb;
  bit mem_init = 1'b0;
  assign rd_comb       = bus.mem_en ? mem_arr[bus.mem_addr] : 32'hBAD0_BAD0;
  assign bus.mem_rdata = (LAT == 1) ? rd_comb : rd_q[LAT-1];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (bus.mem_en && bus.mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) mem_arr[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    rd_q[1] <= rd_comb;
    for (int i = 2; i <= LAT; i++) rd_q[i] <= rd_q[i-1];
  end

  // reference model: one outstanding transaction, timed by its age in cycles
  logic [31:0]   ref_mem [DEPTH];
  bit            m_busy, m_lsu, m_err, m_wen, m_last_lsu;
  int unsigned   m_age;
  logic [31:0]   m_data, m_wdata;
  logic [AW-1:0] m_widx;
  logic [3:0]    m_mask;

  function automatic void launch(bit lsu);
    logic [31:0] a, off;
    bit ok;
    a   = lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
    off = a - BASE;
    ok  = (a >= BASE) && ((off >> 2) < DEPTH) && (a[1:0] == 2'b00);
    m_busy = 1; m_age = 1; m_lsu = lsu; m_err = !ok; m_last_lsu = lsu;
    m_wen  = lsu && bus.lsu_req_wen;
    m_widx = off[AW+1:2];
    m_wdata = bus.lsu_req_wdata;
    m_mask  = bus.lsu_req_wmask;
    if (!ok) m_data = lsu ? 32'd0 : NOP;
    else if (m_wen) begin
      m_data = 32'd0;
      for (int b = 0; b < 4; b++)
        if (m_mask[b]) ref_mem[m_widx][8*b +: 8] = m_wdata[8*b +: 8];
    end else m_data = ref_mem[m_widx];
  endfunction

  initial begin
    bit e_lr, e_ir, e_rv, e_me, lsu_pref;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_busy = 0; m_last_lsu = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chkb("rst_lsu_req_ready", bus.lsu_req_ready, 1'b0);
        chkb("rst_ifu_req_ready", bus.ifu_req_ready, 1'b0);
        m_busy = 0; m_last_lsu = 0;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        lsu_pref = !m_last_lsu;
`else
        lsu_pref = 1'b1;
`endif
        e_lr = !m_busy && bus.lsu_req_valid && (!bus.ifu_req_valid || lsu_pref);
        e_ir = !m_busy && bus.ifu_req_valid && !e_lr;
        e_rv = m_busy && (m_age >= (m_err ? 1 : 1 + LAT));
        e_me = m_busy && !m_err && (m_age == 1);
        chkb("lsu_req_ready", bus.lsu_req_ready, e_lr);
        chkb("ifu_req_ready", bus.ifu_req_ready, e_ir);
        chkb("mem_en", bus.mem_en, e_me);
        chkb("ifu_resp_valid", bus.ifu_resp_valid, e_rv && !m_lsu);
        chkb("lsu_resp_valid", bus.lsu_resp_valid, e_rv && m_lsu);
        if (e_me) begin
          chkb("mem_wen", bus.mem_wen, m_lsu && m_wen);
          chk("mem_addr", 32'(bus.mem_addr), 32'(m_widx));
          if (m_lsu && m_wen) begin
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_wmask", 32'(bus.mem_wmask), 32'(m_mask));
          end
        end
        if (e_rv && m_lsu) begin
          chk("lsu_resp_rdata", bus.lsu_resp_rdata, m_data);
          chkb("lsu_resp_err", bus.lsu_resp_err, m_err);
        end else if (e_rv) begin
          chk("ifu_resp_data", bus.ifu_resp_data, m_data);
          chkb("ifu_resp_err", bus.ifu_resp_err, m_err);
        end
        if (m_busy) begin
          if (e_rv && (m_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready)) m_busy = 0;
          else m_age++;
        end else if (e_lr || e_ir) launch(e_lr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    step();
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
    repeat (LAT + 4) step();
  endtask

  task automatic do_req(input bit lsu, input logic [31:0] addr, input bit wen,
                        input logic [31:0] wd, input logic [3:0] wm,
                        output logic [31:0] rd, output bit er, output bit saw_en,
                        output bit saw_wen, output logic [AW-1:0] maddr);
    bit got;
    saw_en = 0; saw_wen = 0; maddr = '0; rd = '0; er = 0; got = 0;
    bus.lsu_resp_ready = 1; bus.ifu_resp_ready = 1;
    if (lsu) begin
      bus.lsu_req_addr = addr; bus.lsu_req_wen = wen;
      bus.lsu_req_wdata = wd; bus.lsu_req_wmask = wm; bus.lsu_req_valid = 1;
    end else begin
      bus.ifu_req_addr = addr; bus.ifu_req_valid = 1;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
    end
    chkb("req_accept_in_time", got, 1'b1);
    step();
    bus.lsu_req_valid = 0; bus.ifu_req_valid = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin saw_en = 1; saw_wen = bus.mem_wen; maddr = bus.mem_addr; end
      got = lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid;
    end
    chkb("resp_in_time", got, 1'b1);
    rd = lsu ? bus.lsu_resp_rdata : bus.ifu_resp_data;
    er = lsu ? bus.lsu_resp_err : bus.ifu_resp_err;
    drain();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 9)
      0: return BASE + DEPTH * 4 + ($urandom % 64) * 4;
      1: return BASE - 4 - ($urandom % 64) * 4;
      2: return BASE + ($urandom % 32) * 4 + 1 + ($urandom % 3);
      3: return BASE + (DEPTH - 1) * 4;
      4: return 32'hFFFF_FFFC;
      default: return BASE + ($urandom % 32) * 4;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    bit er, saw_en, saw_wen, got;
    logic [AW-1:0] maddr;
    logic [3:0] grants, exp_grants;
    int ng;

    bus.ifu_req_valid = 0; bus.ifu_req_addr = '0; bus.ifu_resp_ready = 0;
    bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
    bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0; bus.lsu_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    chkb("reset_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
    chkb("reset_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
    chkb("reset_mem_en", bus.mem_en, 1'b0);
    chk("reset_ifu_resp_data", bus.ifu_resp_data, 32'd0);

    // fetch of word 0 with cycle-exact timing
    step();
    bus.ifu_resp_ready = 1; bus.ifu_req_addr = BASE; bus.ifu_req_valid = 1;
    @(negedge clk);
    chkb("t1_handshake", bus.ifu_req_ready, 1'b1);
    step();
    bus.ifu_req_valid = 0;
    @(negedge clk);
    chkb("t1_mem_en", bus.mem_en, 1'b1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'd0);
    for (int c = 2; c <= LAT; c++) begin
      @(negedge clk);
      chkb("t1_early_valid", bus.ifu_resp_valid, 1'b0);
    end
    @(negedge clk);
    chkb("t1_resp_valid", bus.ifu_resp_valid, 1'b1);
    chk("t1_resp_data", bus.ifu_resp_data, 32'h0050_0093);
    chkb("t1_resp_err", bus.ifu_resp_err, 1'b0);
    drain();

    do_req(1, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'b0011, rd, er, saw_en, saw_wen, maddr);
    chkb("store_mem_en", saw_en, 1'b1);
    chkb("store_mem_wen", saw_wen, 1'b1);
    chk("store_mem_addr", 32'(maddr), 32'd4);
    chk("store_ack_rdata", rd, 32'd0);
    chkb("store_ack_err", er, 1'b0);

    do_req(1, 32'h8000_0010, 0, 32'd0, 4'b0000, rd, er, saw_en, saw_wen, maddr);
    chk("load_after_store", rd, 32'h4444_BEEF);
    chkb("load_mem_wen", saw_wen, 1'b0);

    do_req(0, 32'h8000_2000, 0, 32'd0, 4'b0000, rd, er, saw_en, saw_wen, maddr);
    chkb("ifu_oor_err", er, 1'b1);
    chk("ifu_oor_data", rd, 32'h0000_0013);
    chkb("ifu_oor_no_mem_en", saw_en, 1'b0);

    do_req(1, 32'h8000_0002, 0, 32'd0, 4'b0000, rd, er, saw_en, saw_wen, maddr);
    chkb("lsu_misaligned_err", er, 1'b1);
    chk("lsu_misaligned_rdata", rd, 32'd0);
    chkb("lsu_misaligned_no_mem_en", saw_en, 1'b0);

    // response backpressure with a competing LSU request pending
    bus.ifu_resp_ready = 0; bus.ifu_req_addr = BASE + 8; bus.ifu_req_valid = 1;
    @(negedge clk);
    chkb("bp_handshake", bus.ifu_req_ready, 1'b1);
    step();
    bus.ifu_req_valid = 0;
    bus.lsu_req_addr = BASE + 32'h20; bus.lsu_req_wen = 0; bus.lsu_req_valid = 1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.ifu_resp_valid;
    end
    chkb("bp_resp_in_time", got, 1'b1);
    held = bus.ifu_resp_data;
    chk("bp_data", held, 32'h2222_2222);
    repeat (5) begin
      @(negedge clk);
      chkb("bp_valid_held", bus.ifu_resp_valid, 1'b1);
      chk("bp_data_held", bus.ifu_resp_data, held);
      chkb("bp_lsu_req_ready", bus.lsu_req_ready, 1'b0);
      chkb("bp_ifu_req_ready", bus.ifu_req_ready, 1'b0);
    end
    step();
    bus.ifu_resp_ready = 1;
    @(negedge clk);
    step();
    @(negedge clk);
    chkb("bp_idle_next", bus.lsu_req_ready, 1'b1);
    drain();

    // reset while waiting on memory
    bus.ifu_req_addr = BASE + 4; bus.ifu_req_valid = 1;
    @(negedge clk);
    chkb("rst_test_handshake", bus.ifu_req_ready, 1'b1);
    step();
    bus.ifu_req_valid = 0;
    step();
    rst_n = 0;
    step();
    @(negedge clk);
    chkb("rst_mid_ifu_valid", bus.ifu_resp_valid, 1'b0);
    chkb("rst_mid_lsu_valid", bus.lsu_resp_valid, 1'b0);
    chkb("rst_mid_mem_en", bus.mem_en, 1'b0);
    step();
    rst_n = 1;
    repeat (2 * LAT + 4) begin
      @(negedge clk);
      chkb("rst_no_stale_resp", bus.ifu_resp_valid, 1'b0);
    end

    // contention: both requesters continuously valid
    step();
    bus.lsu_req_addr = BASE + 32'h40; bus.lsu_req_wen = 0; bus.lsu_req_valid = 1;
    bus.ifu_req_addr = BASE + 32'h44; bus.ifu_req_valid = 1;
    @(negedge clk);
    chkb("post_reset_idle", bus.lsu_req_ready, 1'b1);
    grants = '0;
    ng = 0;
    if (bus.lsu_req_ready || bus.ifu_req_ready) begin grants[0] = bus.lsu_req_ready; ng = 1; end
    for (int c = 0; c < 200 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.lsu_req_ready || bus.ifu_req_ready) begin
        grants[ng] = bus.lsu_req_ready;
        ng++;
      end
    end
    chk("contention_count", 32'(ng), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    exp_grants = 4'b0101;
`else
    exp_grants = 4'b1111;
`endif
    chk("contention_grants", 32'(grants), 32'(exp_grants));
    drain();

    for (int c = 0; c < 3000; c++) begin
      step();
      bus.ifu_req_valid  = ($urandom % 3) != 0;
      bus.lsu_req_valid  = ($urandom % 3) != 0;
      bus.ifu_req_addr   = rand_addr();
      bus.lsu_req_addr   = rand_addr();
      bus.lsu_req_wen    = ($urandom % 2) != 0;
      bus.lsu_req_wdata  = $urandom;
      bus.lsu_req_wmask  = 4'($urandom);
      bus.ifu_resp_ready = ($urandom % 4) != 0;
      bus.lsu_resp_ready = ($urandom % 4) != 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
